tiny_riscv_mem_arbiter: RTL and testbench

- Shares the single-port, 1536-word, byte-masked CPU memory between two requesters: instruction fetch (read-only, port IF) and load/store (port D).
- Sits between the CPU core and the memory block.
- The memory samples address, strobe and mask on a clock edge and returns registered read data after that edge.
- The arbiter sequences each access as a 3-state transaction and arbitrates round-robin.

---
 rtl/tiny_riscv_mem_arbiter_pkg.sv | 16 +
 rtl/tiny_riscv_rr_arbiter2.sv | 22 ++
 rtl/tiny_riscv_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_tiny_riscv_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_riscv_mem_arbiter_pkg.sv
// Shared definitions for the two-port CPU memory arbiter: transaction states,
// requester IDs and the default memory depth.
package tiny_riscv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int DEPTH_WORDS_DEFAULT = 1536;

endpackage

// File: rtl/tiny_riscv_rr_arbiter2.sv
// Two-input round-robin picker. Purely combinational; the last-grant pointer
// lives in the parent so it only advances when a transaction actually starts.
module tiny_riscv_rr_arbiter2
  import tiny_riscv_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = PORT_IF;
    if (req[PORT_D] && req[PORT_IF]) begin
      grant = ~last_grant;
    end else if (req[PORT_D]) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/tiny_riscv_mem_arbiter.sv
// Shares the single-port byte-masked CPU memory between fetch (IF) and load/store (D).
// Each access runs IDLE -> ISSUE -> WAIT. Optional range check: MEM_ARB_RANGE_CHECK_EN.
module tiny_riscv_mem_arbiter
  import tiny_riscv_mem_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int ADDR_W      = 32
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_done,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [3:0]        i_d_wmask,
  output logic              o_d_done,
  output logic [31:0]       o_d_rdata,
  output logic              o_d_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_read_strobe,
  output logic [31:0]       o_mem_write_data,
  output logic [3:0]        o_mem_write_mask,
  input  logic [31:0]       i_mem_data,
  output logic              o_busy,
  output arb_state_t        o_dbg_state
);

  // Handshake: a requester holds req and its inputs stable until its done pulse,
  // and drops req on the edge that ends the done cycle; req seen high in IDLE
  // is always treated as a fresh request.

  arb_state_t        state, state_nx;
  logic              last_grant, grant, any_req;
  logic              winner, is_read, err_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wmask;
  logic              sel_oor, sel_err;
  logic [31:0]       rdata_ret;

  tiny_riscv_rr_arbiter2 u_rr (
    .req        ({i_d_req, i_if_req}),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (any_req)
  );

  always_comb begin
    sel_addr  = i_if_addr;
    sel_wdata = '0;
    sel_wmask = '0;
    if (grant == PORT_D) begin
      sel_addr  = i_d_addr;
      sel_wdata = i_d_wdata;
      sel_wmask = i_d_wmask;
    end
  end

  assign sel_oor = (sel_addr >> 2) >= ADDR_W'(DEPTH_WORDS);

`ifdef MEM_ARB_RANGE_CHECK_EN
  assign sel_err = sel_oor;
`else
  logic unused_range;
  assign unused_range = sel_oor;
  assign sel_err      = 1'b0;
`endif

  // State register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:  state_nx = any_req ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Transaction latch and registered memory-side signals
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      last_grant        <= PORT_D;
      winner            <= PORT_IF;
      is_read           <= 1'b0;
      err_q             <= 1'b0;
      o_mem_addr        <= '0;
      o_mem_read_strobe <= 1'b0;
      o_mem_write_data  <= '0;
      o_mem_write_mask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            last_grant        <= grant;
            winner            <= grant;
            is_read           <= (sel_wmask == 4'h0);
            err_q             <= sel_err;
            o_mem_addr        <= sel_addr;
            o_mem_write_data  <= sel_wdata;
            // An out-of-range access never reaches the memory
            o_mem_read_strobe <= (sel_wmask == 4'h0) && !sel_err;
            o_mem_write_mask  <= sel_err ? 4'h0 : sel_wmask;
          end
        end
        ST_ISSUE: begin
          o_mem_read_strobe <= 1'b0;
          o_mem_write_mask  <= 4'h0;
        end
        default: ;
      endcase
    end
  end

  assign rdata_ret = (is_read && !err_q) ? i_mem_data : 32'h0;

  // Outputs
  always_comb begin
    o_busy      = (state != ST_IDLE);
    o_dbg_state = state;
    o_if_done   = 1'b0;
    o_if_rdata  = '0;
    o_d_done    = 1'b0;
    o_d_rdata   = '0;
    o_d_err     = 1'b0;
    if (state == ST_WAIT) begin
      if (winner == PORT_D) begin
        o_d_done  = 1'b1;
        o_d_rdata = rdata_ret;
        o_d_err   = err_q;
      end else begin
        o_if_done  = 1'b1;
        o_if_rdata = rdata_ret;
      end
    end
  end

endmodule

// File: tb/tb_tiny_riscv_mem_arbiter.sv
// Bench for tiny_riscv_mem_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized two-port traffic scored against a memory reference.
module tb_tiny_riscv_mem_arbiter;
  import tiny_riscv_mem_arbiter_pkg::*;

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        o_if_done;
  logic [31:0] o_if_rdata;
  logic        i_d_req = 1'b0;
  logic [31:0] i_d_addr = '0;
  logic [31:0] i_d_wdata = '0;
  logic [3:0]  i_d_wmask = '0;
  logic        o_d_done;
  logic [31:0] o_d_rdata;
  logic        o_d_err;
  logic [31:0] o_mem_addr;
  logic        o_mem_read_strobe;
  logic [31:0] o_mem_write_data;
  logic [3:0]  o_mem_write_mask;
  logic [31:0] i_mem_data;
  logic        o_busy;
  arb_state_t  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_mode = 1'b0;

  tiny_riscv_mem_arbiter dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_done(o_if_done), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata), .i_d_wmask(i_d_wmask),
    .o_d_done(o_d_done), .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
    .o_mem_addr(o_mem_addr), .o_mem_read_strobe(o_mem_read_strobe),
    .o_mem_write_data(o_mem_write_data), .o_mem_write_mask(o_mem_write_mask),
    .i_mem_data(i_mem_data), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // Memory model: samples on the clock edge, registered read data
  function automatic logic [31:0] preload(input int w);
    logic [7:0] b;
    b = 8'(4 * w - 399);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  logic [31:0] mem [0:1535];
  logic [31:0] mem_rdata;
  logic        do_preload = 1'b0;
  assign i_mem_data = mem_rdata;

  always @(posedge i_Clk) begin
    if (do_preload) begin
      for (int w = 0; w < 1536; w++) mem[w] <= preload(w);
    end else begin
      if (o_mem_read_strobe)
        mem_rdata <= (o_mem_addr[31:2] < 30'd1536) ? mem[o_mem_addr[31:2]] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (o_mem_write_mask[b] && o_mem_addr[31:2] < 30'd1536)
          mem[o_mem_addr[31:2]][b*8 +: 8] <= o_mem_write_data[b*8 +: 8];
    end
  end

  // Reference model: word array updated in service order
  logic [31:0] ref_mem [0:1535];
  logic [67:0] exp_q_if[$];
  logic [67:0] exp_q_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_mem();
    do_preload = 1'b1;
    @(posedge i_Clk); #1;
    do_preload = 1'b0;
    for (int w = 0; w < 1536; w++) ref_mem[w] = preload(w);
  endtask

  task automatic score(input logic port, input logic [31:0] rdata, input logic err);
    logic [67:0] e;
    logic [31:0] a, wd, exp;
    logic [3:0]  m;
    int w;
    bit oor;
    if ((port && exp_q_d.size() == 0) || (!port && exp_q_if.size() == 0)) begin
      checks++; errors++;
      $display("FAIL rand unexpected done: port %0d got done, expected none", port);
      return;
    end
    e = port ? exp_q_d.pop_front() : exp_q_if.pop_front();
    {a, wd, m} = e;
    w   = int'(a[31:2]);
    oor = (w >= 1536);
    exp = (m == 4'h0 && !oor) ? ref_mem[w] : 32'h0;
    chk(port ? "rand d rdata" : "rand if rdata", rdata, exp);
    if (port) chk("rand d err", err, 32'(oor && RC));
    if (m != 4'h0 && !oor)
      for (int b = 0; b < 4; b++) if (m[b]) ref_mem[w][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  // Monitor: global done rules, plus scoring in random mode
  int  last_done_cyc = 0;
  bit  have_last = 1'b0;
  always @(negedge i_Clk) begin
    if (i_Rst) begin
      have_last = 1'b0;
    end else if (o_if_done || o_d_done) begin
      chk("single done", 32'(o_if_done && o_d_done), 32'd0);
      if (have_last) chk("done spacing >= 3", 32'(cyc - last_done_cyc >= 3), 32'd1);
      last_done_cyc = cyc;
      have_last = 1'b1;
      if (rand_mode) begin
        if (o_if_done) score(PORT_IF, o_if_rdata, 1'b0);
        if (o_d_done)  score(PORT_D, o_d_rdata, o_d_err);
      end
    end
  end

  // Directed vectors
  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  // Runs one access starting at posedge+1; returns the done cycle number
  task automatic run_vec(input vec_t v, input int n, output int done_cyc);
    logic       exp_strobe;
    logic [3:0] exp_mask;
    bit         oor;
    oor        = (v.addr[31:2] >= 30'd1536);
    exp_strobe = (v.wmask == 4'h0) && !(RC && oor);
    exp_mask   = (RC && oor) ? 4'h0 : v.wmask;
    if (v.port) begin
      i_d_req = 1'b1; i_d_addr = v.addr; i_d_wdata = v.wdata; i_d_wmask = v.wmask;
    end else begin
      i_if_req = 1'b1; i_if_addr = v.addr;
    end
    @(negedge i_Clk);
    chk($sformatf("v%0d c0 busy", n), o_busy, 0);
    chk($sformatf("v%0d c0 strobe", n), o_mem_read_strobe, 0);
    @(negedge i_Clk);
    chk($sformatf("v%0d c1 busy", n), o_busy, 1);
    chk($sformatf("v%0d c1 strobe", n), o_mem_read_strobe, exp_strobe);
    chk($sformatf("v%0d c1 mask", n), o_mem_write_mask, exp_mask);
    chk($sformatf("v%0d c1 addr", n), o_mem_addr, v.addr);
    chk($sformatf("v%0d c1 wdata", n), o_mem_write_data, v.port ? v.wdata : 32'h0);
    chk($sformatf("v%0d c1 dones", n), {o_if_done, o_d_done}, 0);
    @(negedge i_Clk);
    chk($sformatf("v%0d c2 if_done", n), o_if_done, !v.port);
    chk($sformatf("v%0d c2 d_done", n), o_d_done, v.port);
    chk($sformatf("v%0d c2 rdata", n), v.port ? o_d_rdata : o_if_rdata, v.exp_rdata);
    if (v.port) chk($sformatf("v%0d c2 err", n), o_d_err, v.exp_err);
    chk($sformatf("v%0d c2 strobe", n), o_mem_read_strobe, 0);
    done_cyc = cyc;
    @(posedge i_Clk); #1;
    i_if_req = 1'b0;
    i_d_req  = 1'b0;
  endtask

  // Random drivers
  function automatic logic [31:0] rand_addr();
    int w;
    w = ($urandom_range(0, 19) == 0) ? 1536 + $urandom_range(0, 3) : 96 + $urandom_range(0, 15);
    return {w[29:0], 2'b00};
  endfunction

  task automatic drive_if(input int n);
    bit ok;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(1, 4)) @(posedge i_Clk);
      #1;
      i_if_req = 1'b1; i_if_addr = rand_addr();
      exp_q_if.push_back({i_if_addr, 32'h0, 4'h0});
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge i_Clk);
        if (o_if_done) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL rand if timeout: no done within 10 cycles, expected done");
      end
      @(posedge i_Clk); #1;
      i_if_req = 1'b0;
    end
  endtask

  task automatic drive_d(input int n);
    bit ok;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(1, 4)) @(posedge i_Clk);
      #1;
      i_d_req   = 1'b1;
      i_d_addr  = rand_addr();
      i_d_wdata = $urandom;
      i_d_wmask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      exp_q_d.push_back({i_d_addr, i_d_wdata, i_d_wmask});
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge i_Clk);
        if (o_d_done) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL rand d timeout: no done within 10 cycles, expected done");
      end
      @(posedge i_Clk); #1;
      i_d_req = 1'b0;
    end
  endtask

  int dc[13];

  initial begin
    vecs[0]  = '{PORT_IF, 32'h190,  32'h0,        4'h0, 32'h04030201, 1'b0};
    vecs[1]  = '{PORT_D,  32'h194,  32'h000000AA, 4'h1, 32'h0,        1'b0};
    vecs[2]  = '{PORT_D,  32'h194,  32'h0,        4'h0, 32'h080706AA, 1'b0};
    vecs[3]  = '{PORT_D,  32'h198,  32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[4]  = '{PORT_IF, 32'h198,  32'h0,        4'h0, 32'h11223344, 1'b0};
    vecs[5]  = '{PORT_D,  32'h19C,  32'h0000BB00, 4'h2, 32'h0,        1'b0};
    vecs[6]  = '{PORT_D,  32'h19C,  32'h0,        4'h0, 32'h100FBB0D, 1'b0};
    vecs[7]  = '{PORT_D,  32'h190,  32'hCAFE0000, 4'hC, 32'h0,        1'b0};
    vecs[8]  = '{PORT_IF, 32'h190,  32'h0,        4'h0, 32'hCAFE0201, 1'b0};
    vecs[9]  = '{PORT_D,  32'h1800, 32'h0,        4'h0, 32'h0,        RC};
    vecs[10] = '{PORT_IF, 32'h1800, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[11] = '{PORT_D,  32'h193,  32'h0,        4'h0, 32'hCAFE0201, 1'b0};
    vecs[12] = '{PORT_D,  32'h1804, 32'h00000001, 4'hF, 32'h0,        RC};

    // Reset state
    @(negedge i_Clk);
    chk("rst busy", o_busy, 0);
    chk("rst state", 32'(o_dbg_state), 32'(ST_IDLE));
    chk("rst mem outs", {o_mem_addr, o_mem_write_data}, 0);
    chk("rst strobe/mask", {o_mem_read_strobe, o_mem_write_mask}, 0);
    chk("rst dones", {o_if_done, o_d_done, o_d_err}, 0);
    chk("rst rdata", o_if_rdata | o_d_rdata, 0);
    load_mem();
    i_Rst = 1'b0;

    // Table-driven single accesses
    @(posedge i_Clk); #1;
    for (int n = 0; n < 13; n++) run_vec(vecs[n], n, dc[n]);
    chk("store->load done spacing", 32'(dc[2] - dc[1]), 32'd3);

    // Both requesting from reset: IF, D, IF, D
    load_mem();
    i_Rst = 1'b1;
    i_if_req = 1'b1; i_if_addr = 32'h190;
    i_d_req = 1'b1; i_d_addr = 32'h194; i_d_wmask = 4'h0;
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_Clk);
      chk($sformatf("alt c%0d if_done", c), o_if_done, (c == 2 || c == 8));
      chk($sformatf("alt c%0d d_done", c), o_d_done, (c == 5 || c == 11));
      if (o_if_done) chk($sformatf("alt c%0d if_rdata", c), o_if_rdata, 32'h04030201);
      if (o_d_done)  chk($sformatf("alt c%0d d_rdata", c), o_d_rdata, 32'h08070605);
      @(posedge i_Clk); #1;
    end
    i_if_req = 1'b0; i_d_req = 1'b0;
    repeat (2) @(posedge i_Clk); #1;

    // Reset during ISSUE of a D store
    i_d_req = 1'b1; i_d_addr = 32'h1A0; i_d_wdata = 32'h55; i_d_wmask = 4'hF;
    @(negedge i_Clk);
    @(negedge i_Clk);
    chk("rstmid issue mask", o_mem_write_mask, 4'hF);
    #1;
    i_Rst = 1'b1; i_d_req = 1'b0;
    #1;
    chk("rstmid busy", o_busy, 0);
    chk("rstmid mask/strobe", {o_mem_write_mask, o_mem_read_strobe}, 0);
    chk("rstmid addr/wdata", {o_mem_addr, o_mem_write_data}, 0);
    chk("rstmid dones", {o_d_done, o_if_done, o_d_err}, 0);
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_Clk);
      chk($sformatf("rstmid after k%0d d_done", k), o_d_done, 0);
      chk($sformatf("rstmid after k%0d state", k), 32'(o_dbg_state), 32'(ST_IDLE));
    end
    @(posedge i_Clk); #1;

    // IF req held across done; D joins later and is served by round-robin
    load_mem();
    i_if_req = 1'b1; i_if_addr = 32'h190;
    for (int c = 0; c < 13; c++) begin
      @(negedge i_Clk);
      chk($sformatf("hold c%0d if_done", c), o_if_done, (c == 2 || c == 5 || c == 11));
      chk($sformatf("hold c%0d d_done", c), o_d_done, (c == 8));
      if (c == 4) chk("hold c4 second fetch strobe", o_mem_read_strobe, 1);
      @(posedge i_Clk); #1;
      if (c == 4) begin i_d_req = 1'b1; i_d_addr = 32'h194; i_d_wmask = 4'h0; end
      if (c == 8) i_d_req = 1'b0;
      if (c == 11) i_if_req = 1'b0;
    end
    repeat (2) @(posedge i_Clk); #1;

    // Randomized two-port traffic
    i_Rst = 1'b1;
    load_mem();
    i_Rst = 1'b0;
    rand_mode = 1'b1;
    fork
      drive_if(40);
      drive_d(40);
    join
    repeat (4) @(posedge i_Clk);
    rand_mode = 1'b0;
    chk("rand queues drained", 32'(exp_q_if.size() + exp_q_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
